// File: rtl/ex_mem_stage.sv
// LEGv8 execute stage plus EX/MEM pipeline register.
// Single-cycle ALU ops and a shift-add multiply that holds ID/EX while it iterates.
module ex_mem_stage #(
  parameter int WIDTH      = 64,
  parameter int MUL_CYCLES = 64
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             IValid,
  input  logic             IFlush,
  input  logic [WIDTH-1:0] IReadData1,
  input  logic [WIDTH-1:0] IReadData2,
  input  logic [WIDTH-1:0] ISignExtend,
  input  logic [WIDTH-1:0] IRegisterPC,
  input  logic [2:0]       IEX,
  input  logic [2:0]       IM,
  input  logic [1:0]       IWB,
  input  logic [10:0]      IInstruction3121,
  input  logic [4:0]       IInstruction40,
  output logic             OStall,
  output logic             OValid,
  output logic [WIDTH-1:0] OALUResult,
  output logic             OZero,
  output logic [WIDTH-1:0] OBranchTarget,
  output logic [WIDTH-1:0] OReadData2,
  output logic [2:0]       OM,
  output logic [1:0]       OWB,
  output logic [4:0]       OInstruction40
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(MUL_CYCLES - 1);

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Copies of the multiply's side-band fields, so ID/EX may change under us.
  logic [WIDTH-1:0] savedTarget_q, savedTarget_d;
  logic [WIDTH-1:0] savedReadData2_q, savedReadData2_d;
  logic [2:0]       savedM_q, savedM_d;
  logic [1:0]       savedWB_q, savedWB_d;
  logic [4:0]       savedRd_q, savedRd_d;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] readData2_q, readData2_d;
  logic [2:0]       m_q, m_d;
  logic [1:0]       wb_q, wb_d;
  logic [4:0]       rd_q, rd_d;

  logic [WIDTH-1:0] operandB;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] branchTarget;
  logic [WIDTH-1:0] accNext;
  logic             isMul;
  logic             lastIter;

  assign operandB     = IEX[2] ? ISignExtend : IReadData2;
  assign branchTarget = IRegisterPC + (ISignExtend << 2);
  assign isMul        = (IEX[1:0] == 2'b10) && (IInstruction3121 == OP_MUL);
  assign accNext      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign lastIter     = (count_q == LAST_COUNT);

  always_comb begin
    aluResult = '0;
    case (IEX[1:0])
      2'b00: aluResult = IReadData1 + operandB;
      2'b01: aluResult = operandB;
      2'b10: begin
        case (IInstruction3121)
          OP_ADD:  aluResult = IReadData1 + operandB;
          OP_SUB:  aluResult = IReadData1 - operandB;
          OP_AND:  aluResult = IReadData1 & operandB;
          OP_ORR:  aluResult = IReadData1 | operandB;
          default: aluResult = '0;
        endcase
      end
      default: aluResult = '0;
    endcase
  end

  // Next-state logic; a bubble clears only valid/WB/M and holds everything else.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    acc_d            = acc_q;
    mcand_d          = mcand_q;
    mplier_d         = mplier_q;
    savedTarget_d    = savedTarget_q;
    savedReadData2_d = savedReadData2_q;
    savedM_d         = savedM_q;
    savedWB_d        = savedWB_q;
    savedRd_d        = savedRd_q;
    valid_d          = 1'b0;
    result_d         = result_q;
    zero_d           = zero_q;
    target_d         = target_q;
    readData2_d      = readData2_q;
    m_d              = 3'b000;
    wb_d             = 2'b00;
    rd_d             = rd_q;

    if (IFlush) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (IValid && isMul) begin
            state_d          = ST_MUL;
            count_d          = '0;
            acc_d            = '0;
            mcand_d          = IReadData1;
            mplier_d         = operandB;
            savedTarget_d    = branchTarget;
            savedReadData2_d = IReadData2;
            savedM_d         = IM;
            savedWB_d        = IWB;
            savedRd_d        = IInstruction40;
          end else if (IValid) begin
            valid_d     = 1'b1;
            result_d    = aluResult;
            zero_d      = (aluResult == '0);
            target_d    = branchTarget;
            readData2_d = IReadData2;
            m_d         = IM;
            wb_d        = IWB;
            rd_d        = IInstruction40;
          end
        end
        ST_MUL: begin
          acc_d    = accNext;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + 1'b1;
          if (lastIter) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            valid_d     = 1'b1;
            result_d    = accNext;
            zero_d      = (accNext == '0);
            target_d    = savedTarget_q;
            readData2_d = savedReadData2_q;
            m_d         = savedM_q;
            wb_d        = savedWB_q;
            rd_d        = savedRd_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q          <= ST_IDLE;
      count_q          <= '0;
      acc_q            <= '0;
      mcand_q          <= '0;
      mplier_q         <= '0;
      savedTarget_q    <= '0;
      savedReadData2_q <= '0;
      savedM_q         <= '0;
      savedWB_q        <= '0;
      savedRd_q        <= '0;
      valid_q          <= 1'b0;
      result_q         <= '0;
      zero_q           <= 1'b0;
      target_q         <= '0;
      readData2_q      <= '0;
      m_q              <= '0;
      wb_q             <= '0;
      rd_q             <= '0;
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      acc_q            <= acc_d;
      mcand_q          <= mcand_d;
      mplier_q         <= mplier_d;
      savedTarget_q    <= savedTarget_d;
      savedReadData2_q <= savedReadData2_d;
      savedM_q         <= savedM_d;
      savedWB_q        <= savedWB_d;
      savedRd_q        <= savedRd_d;
      valid_q          <= valid_d;
      result_q         <= result_d;
      zero_q           <= zero_d;
      target_q         <= target_d;
      readData2_q      <= readData2_d;
      m_q              <= m_d;
      wb_q             <= wb_d;
      rd_q             <= rd_d;
    end
  end

  // Stall is forced low in reset so every output reads 0 while Rst_n is asserted.
  assign OStall = Rst_n && !IFlush &&
                  ((state_q == ST_IDLE && IValid && isMul) ||
                   (state_q == ST_MUL && !lastIter));

  assign OValid         = valid_q;
  assign OALUResult     = result_q;
  assign OZero          = zero_q;
  assign OBranchTarget  = target_q;
  assign OReadData2     = readData2_q;
  assign OM             = m_q;
  assign OWB            = wb_q;
  assign OInstruction40 = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: ALU ops, iterative multiply, stall length,
// bubbles, flush and reset aborts.
module tb_ex_mem_stage;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        IValid = 1'b0;
  logic        IFlush = 1'b0;
  logic [63:0] IReadData1 = '0;
  logic [63:0] IReadData2 = '0;
  logic [63:0] ISignExtend = '0;
  logic [63:0] IRegisterPC = '0;
  logic [2:0]  IEX = '0;
  logic [2:0]  IM = '0;
  logic [1:0]  IWB = '0;
  logic [10:0] IInstruction3121 = '0;
  logic [4:0]  IInstruction40 = '0;
  logic        OStall;
  logic        OValid;
  logic [63:0] OALUResult;
  logic        OZero;
  logic [63:0] OBranchTarget;
  logic [63:0] OReadData2;
  logic [2:0]  OM;
  logic [1:0]  OWB;
  logic [4:0]  OInstruction40;

  ex_mem_stage #(.WIDTH(64), .MUL_CYCLES(64)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IValid(IValid), .IFlush(IFlush),
    .IReadData1(IReadData1), .IReadData2(IReadData2), .ISignExtend(ISignExtend),
    .IRegisterPC(IRegisterPC), .IEX(IEX), .IM(IM), .IWB(IWB),
    .IInstruction3121(IInstruction3121), .IInstruction40(IInstruction40),
    .OStall(OStall), .OValid(OValid), .OALUResult(OALUResult), .OZero(OZero),
    .OBranchTarget(OBranchTarget), .OReadData2(OReadData2), .OM(OM), .OWB(OWB),
    .OInstruction40(OInstruction40)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] a, rd2, se, pc;
    logic [2:0]  ex, m;
    logic [1:0]  wb;
    logic [10:0] op;
    logic [4:0]  rd;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic [63:0] tgt;
    logic [63:0] rd2;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [4:0]  rd;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mkVec(input logic [63:0] a, rd2, se, pc, input logic [2:0] ex, m,
                                 input logic [1:0] wb, input logic [10:0] op, input logic [4:0] rd);
    vec_t v;
    v.a = a; v.rd2 = rd2; v.se = se; v.pc = pc;
    v.ex = ex; v.m = m; v.wb = wb; v.op = op; v.rd = rd;
    return v;
  endfunction

  function automatic logic [63:0] modelAlu(input vec_t v);
    logic [63:0] b;
    b = v.ex[2] ? v.se : v.rd2;
    case (v.ex[1:0])
      2'b00: return v.a + b;
      2'b01: return b;
      2'b10: begin
        if (v.op == OP_ADD) return v.a + b;
        if (v.op == OP_SUB) return v.a - b;
        if (v.op == OP_AND) return v.a & b;
        if (v.op == OP_ORR) return v.a | b;
        if (v.op == OP_MUL) return v.a * b;
        return 64'd0;
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic exp_t makeExp(input vec_t v);
    exp_t e;
    e.res  = modelAlu(v);
    e.zero = (e.res == 64'd0);
    e.tgt  = v.pc + (v.se << 2);
    e.rd2  = v.rd2;
    e.m    = v.m;
    e.wb   = v.wb;
    e.rd   = v.rd;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o = {OALUResult, OZero, OBranchTarget, OReadData2, OM, OWB, OInstruction40};
    return o;
  endfunction

  task automatic present(input vec_t v);
    IValid = 1'b1;
    IFlush = 1'b0;
    IReadData1 = v.a;
    IReadData2 = v.rd2;
    ISignExtend = v.se;
    IRegisterPC = v.pc;
    IEX = v.ex;
    IM = v.m;
    IWB = v.wb;
    IInstruction3121 = v.op;
    IInstruction40 = v.rd;
  endtask

  task automatic test_reset;
    present(mkVec(64'd7, 64'd6, 64'd1, 64'h40, 3'b010, 3'b111, 2'b11, OP_MUL, 5'd1));
    #2 Rst_n = 1'b0;
    #1;
    total++;
    if ({observed(), OValid, OStall} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h valid=%b stall=%b exp=all zero", observed(), OValid, OStall);
    end
    IValid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    total++;
    if ({OValid, OStall, OWB, OM} !== 7'b0) begin
      bad++;
      $display("[TB] FAIL reset_idle got valid=%b stall=%b wb=%b m=%b exp=0", OValid, OStall, OWB, OM);
    end
  endtask

  task automatic test_alu;
    vec_t vecs[9];
    exp_t e;
    exp_t got;
    logic [63:0] lastRes;
    logic [4:0] lastRd;
    vecs[0] = mkVec(64'd5, 64'd7, 64'd0, 64'd0, 3'b010, 3'b101, 2'b11, OP_ADD, 5'd3);
    vecs[1] = mkVec(64'h1234, 64'h1234, 64'd0, 64'h8, 3'b010, 3'b010, 2'b01, OP_SUB, 5'd4);
    vecs[2] = mkVec(64'd99, 64'd0, 64'd4, 64'h100, 3'b001, 3'b100, 2'b00, 11'h5A0, 5'd0);
    vecs[3] = mkVec(64'h1000, 64'h55, 64'hFFFF_FFFF_FFFF_FFF8, 64'h20, 3'b100, 3'b001, 2'b10, OP_LDUR, 5'd7);
    vecs[4] = mkVec(64'hF0F0, 64'hFF00, 64'd2, 64'h30, 3'b010, 3'b000, 2'b10, OP_AND, 5'd8);
    vecs[5] = mkVec(64'hF0F0, 64'h0F0F, 64'd3, 64'h34, 3'b010, 3'b000, 2'b10, OP_ORR, 5'd9);
    vecs[6] = mkVec(64'd1, 64'd2, 64'd5, 64'h38, 3'b011, 3'b011, 2'b11, OP_ADD, 5'd10);
    vecs[7] = mkVec(64'd1, 64'd2, 64'd6, 64'h3C, 3'b010, 3'b110, 2'b01, 11'h7FF, 5'd11);
    vecs[8] = mkVec(64'd3, 64'd5, 64'd7, 64'h44, 3'b010, 3'b010, 2'b10, OP_SUB, 5'd12);
    lastRes = '0;
    lastRd = '0;
    for (int i = 0; i < 9; i++) begin
      present(vecs[i]);
      expQ.push_back(makeExp(vecs[i]));
      @(posedge Clk); #1;
      total++;
      if (OValid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL alu_valid[%0d] got=%b exp=1", i, OValid);
      end
      if (OValid === 1'b1) begin
        got = observed();
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL alu_scoreboard[%0d] got=output exp=empty queue", i);
        end else begin
          e = expQ.pop_front();
          lastRes = e.res;
          lastRd = e.rd;
          if (got !== e) begin
            bad++;
            $display("[TB] FAIL alu_result[%0d] got=%h exp=%h", i, got, e);
          end
        end
      end
      if (i == 0) begin
        total++;
        if ({OALUResult, OZero, OWB, OM} !== {64'd12, 1'b0, 2'b11, 3'b101}) begin
          bad++;
          $display("[TB] FAIL add_5_7 got=%h z=%b wb=%b m=%b exp=c 0 11 101", OALUResult, OZero, OWB, OM);
        end
      end else if (i == 1) begin
        total++;
        if ({OALUResult, OZero} !== {64'd0, 1'b1}) begin
          bad++;
          $display("[TB] FAIL sub_equal got=%h z=%b exp=0 1", OALUResult, OZero);
        end
      end else if (i == 2) begin
        total++;
        if ({OZero, OBranchTarget} !== {1'b1, 64'h110}) begin
          bad++;
          $display("[TB] FAIL cbz_target got z=%b tgt=%h exp=1 110", OZero, OBranchTarget);
        end
      end else if (i == 3) begin
        total++;
        if (OALUResult !== 64'hFF8) begin
          bad++;
          $display("[TB] FAIL alusrc got=%h exp=ff8", OALUResult);
        end
      end
    end
    IValid = 1'b0;
    @(posedge Clk); #1;
    total++;
    if ({OValid, OWB, OM, OALUResult, OInstruction40} !== {6'b0, lastRes, lastRd}) begin
      bad++;
      $display("[TB] FAIL bubble_hold got v=%b wb=%b m=%b res=%h rd=%0d exp=0 0 0 %h %0d",
               OValid, OWB, OM, OALUResult, OInstruction40, lastRes, lastRd);
    end
  endtask

  task automatic test_mul(input logic [63:0] a, b, prod, input string tag);
    vec_t v;
    exp_t e;
    exp_t got;
    int stallCycles;
    stallCycles = 0;
    v = mkVec(a, b, 64'd16, 64'h200, 3'b010, 3'b010, 2'b10, OP_MUL, 5'd9);
    present(v);
    expQ.push_back(makeExp(v));
    #1;
    while (OStall === 1'b1 && stallCycles < 200) begin
      stallCycles++;
      @(posedge Clk); #1;
      if (stallCycles == 1) begin
        IReadData1 = ~a;
        IReadData2 = a ^ b ^ 64'h5A;
        IRegisterPC = 64'hDEAD;
      end
      total++;
      if ({OValid, OWB, OM} !== 6'b0) begin
        bad++;
        $display("[TB] FAIL %s_bubble[%0d] got v=%b wb=%b m=%b exp=0", tag, stallCycles, OValid, OWB, OM);
      end
    end
    total++;
    if (stallCycles != 64) begin
      bad++;
      $display("[TB] FAIL %s_stall_len got=%0d exp=64", tag, stallCycles);
    end
    @(posedge Clk); #1;
    total++;
    if (OValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_valid got=%b exp=1", tag, OValid);
    end
    if (OValid === 1'b1) begin
      got = observed();
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL %s_scoreboard got=output exp=empty queue", tag);
      end else begin
        e = expQ.pop_front();
        if (got !== e) begin
          bad++;
          $display("[TB] FAIL %s_result got=%h exp=%h", tag, got, e);
        end
      end
    end
    total++;
    if ({OALUResult, OZero} !== {prod, (prod == 64'd0)}) begin
      bad++;
      $display("[TB] FAIL %s_product got=%h z=%b exp=%h", tag, OALUResult, OZero, prod);
    end
    IValid = 1'b0;
  endtask

  task automatic test_back_to_back;
    vec_t v;
    exp_t e;
    test_mul(64'd7, 64'd6, 64'd42, "mul7x6");
    v = mkVec(64'd100, 64'd23, 64'd1, 64'h300, 3'b010, 3'b001, 2'b01, OP_ADD, 5'd21);
    present(v);
    expQ.push_back(makeExp(v));
    @(posedge Clk); #1;
    total++;
    if (OValid !== 1'b1 || expQ.size() == 0) begin
      bad++;
      $display("[TB] FAIL b2b_valid got=%b exp=1", OValid);
    end else begin
      e = expQ.pop_front();
      if (observed() !== e) begin
        bad++;
        $display("[TB] FAIL b2b_result got=%h exp=%h", observed(), e);
      end
    end
    IValid = 1'b0;
  endtask

  task automatic test_flush;
    int seen;
    present(mkVec(64'd9, 64'd9, 64'd0, 64'h0, 3'b010, 3'b111, 2'b11, OP_ADD, 5'd2));
    IFlush = 1'b1;
    @(posedge Clk); #1;
    total++;
    if ({OValid, OWB, OM} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL flush_alu got v=%b wb=%b m=%b exp=0", OValid, OWB, OM);
    end
    present(mkVec(64'd7, 64'd6, 64'd0, 64'h0, 3'b010, 3'b010, 2'b10, OP_MUL, 5'd5));
    repeat (20) @(posedge Clk);
    #1;
    total++;
    if (OStall !== 1'b1) begin
      bad++;
      $display("[TB] FAIL flush_prestall got=%b exp=1", OStall);
    end
    IFlush = 1'b1;
    #1;
    total++;
    if (OStall !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_stall got=%b exp=0", OStall);
    end
    @(posedge Clk); #1;
    IFlush = 1'b0;
    IValid = 1'b0;
    total++;
    if ({OValid, OWB, OM} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL flush_bubble got v=%b wb=%b m=%b exp=0", OValid, OWB, OM);
    end
    seen = 0;
    repeat (70) begin
      @(posedge Clk); #1;
      if (OValid === 1'b1 || OStall === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("[TB] FAIL flush_quiet got=%0d active cycles exp=0", seen);
    end
    test_mul(64'd11, 64'd13, 64'd143, "mul_after_flush");
  endtask

  task automatic test_reset_mid_mul;
    present(mkVec(64'h1234, 64'h10, 64'd0, 64'h0, 3'b010, 3'b010, 2'b10, OP_MUL, 5'd6));
    repeat (30) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    #1;
    total++;
    if ({observed(), OValid, OStall} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid got=%h valid=%b stall=%b exp=all zero", observed(), OValid, OStall);
    end
    IValid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    test_mul(64'd3, 64'd5, 64'd15, "mul_after_reset");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, "mul_neg1x3");
    test_mul(64'h1_0000_0000, 64'h1_0000_0000, 64'd0, "mul_2p32");
    test_flush();
    test_reset_mid_mul();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending exp=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 64-bit LEGv8 pipeline; sits directly downstream of the ID/EX register and consumes its outputs.
- Performs single-cycle ALU operations and an iterative 64-cycle multiply. While a multiply runs, it stalls the ID/EX register.
- Registers the ALU result, zero flag, branch target, store data and the forwarded WB/M control fields for the MEM stage.

Parameters:
- WIDTH, 64, datapath width. Only 64 is verified.
- MUL_CYCLES, 64, iterations per multiply. Must equal WIDTH.

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- IValid  in  1  ID/EX holds a valid instruction
- IFlush  in  1  synchronous flush: squash the current operation
- IReadData1  in  64  operand A
- IReadData2  in  64  operand B / store data
- ISignExtend  in  64  sign-extended immediate
- IRegisterPC  in  64  instruction PC
- IEX  in  3  [2]=ALUSrc, [1:0]=ALUOp
- IM  in  3  MEM control, forwarded
- IWB  in  2  WB control, forwarded
- IInstruction3121  in  11  opcode
- IInstruction40  in  5  Rd, forwarded
- OStall  out  1  hold ID/EX and upstream stages (combinational)
- OValid  out  1  EX/MEM holds a valid instruction
- OALUResult  out  64  result
- OZero  out  1  OALUResult == 0
- OBranchTarget  out  64  IRegisterPC + (ISignExtend << 2), mod 2^64
- OReadData2  out  64  forwarded store data
- OM  out  3  forwarded MEM control
- OWB  out  2  forwarded WB control
- OInstruction40  out  5  forwarded Rd

Behaviour:
- Reset (async, Rst_n=0): all outputs 0; state IDLE; counter 0; OStall=0.
- Operand B select: B = IEX[2] ? ISignExtend : IReadData2.
- ALU control:
  - ALUOp 00: ADD.
  - ALUOp 01: pass B (CBZ).
  - ALUOp 10, by opcode: 10001011000 ADD; 11001011000 SUB; 10001010000 AND; 10101010000 ORR; 10011011000 MUL.
  - Any other opcode, or ALUOp 11: result 0.
- Arithmetic is mod 2^64. MUL returns the low 64 bits of the product (same for signed and unsigned).
- States: IDLE, MUL.
- IDLE, IValid=1, non-MUL: result, zero, branch target and forwarded fields registered at the next edge; OValid=1. Latency 1 cycle.
- IDLE, IValid=1, MUL: at the edge, load acc=0, mcand=A, mplier=B, count=0; go to MUL. The bubble rule applies at this edge.
- MUL state, each edge:
  - If mplier[0]=1, acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, count++.
  - At the edge with count==63: write the final acc to OALUResult with OZero, OBranchTarget and the forwarded fields; OValid=1; return to IDLE.
- OStall = (IDLE & IValid & isMUL & !IFlush) | (MUL & count!=63 & !IFlush).
  - Stall lasts 64 cycles; OValid for the multiply rises 65 edges after the MUL is first presented.
  - Upstream advances on the count==63 edge; a new instruction presented in IDLE is accepted back-to-back.
- Bubble: on any edge where IValid=0, or a MUL is accepted, or the MUL state has count<63, drive OValid=0, OWB=0 and OM=0. All other outputs hold their previous values.
- IFlush=1 (priority over everything except reset): at the next edge, bubble the outputs, go to IDLE, clear count. Any running MUL is discarded and OStall drops combinationally.
- Reset mid-MUL: immediate return to the reset state; the partial product is discarded.
- Inputs are sampled only at the acceptance edge. A multiply uses its internal copies, so input changes during MUL are ignored.

Test Plan:
- ADD: A=5, B=7, ALUOp=10, opcode 10001011000 -> next edge OALUResult=12, OZero=0, OValid=1, OWB/OM equal the inputs.
- SUB: A=B=0x1234 -> OALUResult=0, OZero=1. Then CBZ (ALUOp=01) with IReadData2=0 -> OZero=1. Then PC=0x100, ISignExtend=4 -> OBranchTarget=0x110.
- ALUSrc: IEX[2]=1, ALUOp=00, A=0x1000, ISignExtend=0xFFFF_FFFF_FFFF_FFF8 -> OALUResult=0xFF8.
- MUL: A=7, B=6.
  - OStall=1 for exactly 64 cycles; OValid=0, OWB=0, OM=0 during the stall.
  - OALUResult=42 with OValid=1 at edge 65.
  - Follow-on ADD issues back-to-back.
- MUL: A=0xFFFF_FFFF_FFFF_FFFF, B=3 -> OALUResult=0xFFFF_FFFF_FFFF_FFFD. Then A=2^32, B=2^32 -> OALUResult=0, OZero=1.
- Abort: IFlush pulsed at MUL cycle 20 -> OStall=0 that cycle, no result, IDLE. Separate run: Rst_n low at cycle 30 -> all outputs 0 immediately, next MUL correct.
